// File: rtl/core_pkg.sv
// Shared core definitions: result-source indices, load-size encodings, register address width.
// Constants only; nothing here has latency or backpressure.
package core_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } res_src_e;

  localparam logic [1:0] LS_B = 2'b00;
  localparam logic [1:0] LS_H = 2'b01;
  localparam logic [1:0] LS_W = 2'b10;

  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension; purely combinational (zero latency).
// No handshake: the output follows the inputs every cycle.
module load_extend
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       load_size_i,
  input  logic             load_unsigned_i,
  input  logic [1:0]       byte_offset_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] word_lane;
  logic        fill;

  always_comb begin
    byte_lane = data_i[{byte_offset_i, 3'b000} +: 8];
    half_lane = data_i[{byte_offset_i[1], 4'b0000} +: 16];
    word_lane = data_i[31:0];
    fill      = 1'b0;
    data_o    = '0;
    case (load_size_i)
      LS_B: begin
        fill        = ~load_unsigned_i & byte_lane[7];
        data_o      = {WIDTH{fill}};
        data_o[7:0] = byte_lane;
      end
      LS_H: begin
        fill         = ~load_unsigned_i & half_lane[15];
        data_o       = {WIDTH{fill}};
        data_o[15:0] = half_lane;
      end
      // LS_W and the reserved encoding both load the full word
      default: begin
        fill         = ~load_unsigned_i & word_lane[31];
        data_o       = {WIDTH{fill}};
        data_o[31:0] = word_lane;
      end
    endcase
  end

endmodule

// File: rtl/wb_result_stage.sv
// Writeback result select + load extension into a MEM/WB register; 1-cycle latency.
// stall holds the register, flush inserts a bubble (flush wins over stall).
module wb_result_stage
  import core_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int MEM_IDX = int'(RES_MEM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]        result_src,
  input  logic [1:0]              load_size,
  input  logic                    load_unsigned,
  input  logic [1:0]              byte_offset,
  input  logic [REG_ADDR_W-1:0]   rd_in,
  input  logic                    reg_write_in,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        result,
  output logic [REG_ADDR_W-1:0]   rd_out,
  output logic                    reg_write_out
);

  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] ext_val;
  logic [WIDTH-1:0] wb_val;

  // Out-of-range selects fall through to zero
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (result_src == SEL_W'(i)) sel_val = src_data[i*WIDTH +: WIDTH];
    end
  end

  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .data_i          (sel_val),
    .load_size_i     (load_size),
    .load_unsigned_i (load_unsigned),
    .byte_offset_i   (byte_offset),
    .data_o          (ext_val)
  );

  assign wb_val = (result_src == SEL_W'(MEM_IDX)) ? ext_val : sel_val;

  logic                  valid_q, valid_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  we_q, we_d;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    we_d     = we_q;
    if (flush) begin
      valid_d  = 1'b0;
      result_d = '0;
      rd_d     = '0;
      we_d     = 1'b0;
    end else if (!stall) begin
      valid_d  = in_valid;
      result_d = wb_val;
      rd_d     = rd_in;
      we_d     = reg_write_in & in_valid & (rd_in != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
    end
  end

  assign out_valid     = valid_q;
  assign result        = result_q;
  assign rd_out        = rd_q;
  assign reg_write_out = we_q;

endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
Parametrised writeback result stage for the pipelined RV32I core. It replaces the fixed 2:1 data-memory/ALU result select with an N-source select, load-data extraction/extension, and a MEM/WB pipeline register with stall and flush. Its output drives the register-file write port and the forwarding unit.

Parameters:
WIDTH, 32, datapath width in bits (multiple of 8, at least 32)
NUM_SRC, 4, number of result sources (at least 2); index 0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate
SEL_W, $clog2(NUM_SRC), result_src width
MEM_IDX, 1, source index that receives load extension

Ports:
clk  input  1  clock, all state on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream instruction valid this cycle
stall  input  1  hold the stage register
flush  input  1  replace the captured instruction with a bubble
src_data  input  NUM_SRC*WIDTH  packed sources; source i at bits [i*WIDTH +: WIDTH]
result_src  input  SEL_W  source select
load_size  input  2  00 byte, 01 half, 10 word, 11 reserved
load_unsigned  input  1  1 = zero-extend, 0 = sign-extend
byte_offset  input  2  address[1:0] of the load
rd_in  input  5  destination register
reg_write_in  input  1  write enable from decode
out_valid  output  1  registered valid
result  output  WIDTH  registered writeback value
rd_out  output  5  registered destination
reg_write_out  output  1  registered write enable, gated by validity

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Combinational front end:
  - sel_val = src_data slice[result_src].
  - If result_src >= NUM_SRC, sel_val = 0.
- Load extension applies only when result_src == MEM_IDX:
  - byte: lane = sel_val[8*byte_offset +: 8], extended to WIDTH.
  - half: lane = sel_val[16*byte_offset[1] +: 16], extended; byte_offset[0] is ignored (no misalign trap here).
  - word: sel_val[31:0]; bits above 31 (when WIDTH > 32) are zero-extended if load_unsigned, else sign-extended.
  - reserved (11): treated as word.
  - Sign-extend uses the lane MSB; zero-extend pads with 0.
- For any other source, the value passes unmodified; load_size, load_unsigned and byte_offset are ignored.
- Stage register, priority rst > flush > stall > capture:
  - rst: out_valid=0, result=0, rd_out=0, reg_write_out=0.
  - flush (stall is don't-care): out_valid=0, reg_write_out=0; result and rd_out are cleared to 0.
  - stall (no flush): all outputs hold their values.
  - otherwise: out_valid<=in_valid; result<=extended value; rd_out<=rd_in; reg_write_out<=reg_write_in & in_valid & (rd_in != 0).
- Latency: exactly 1 cycle from input to outputs. The stage accepts one instruction per cycle when not stalled.
- The x0 guard is applied here, so reg_write_out is never 1 with rd_out == 0.
- If in_valid=0, the captured result is don't-care but deterministic (the computed value is still registered). reg_write_out is 0.
- Reset during a stall clears the stage. Stall released after a flush leaves the bubble in place until the next capture.

Decomposition:
- Shared package core_pkg:
  - result_src enum constants RES_ALU=0, RES_MEM=1, RES_PC4=2, RES_IMM=3.
  - load_size constants LS_B, LS_H, LS_W.
  - REG_ADDR_W=5.
- One sub-module, load_extend: purely combinational lane select and extension, parametrised on WIDTH, and reusable by the data-memory path. The mux and pipeline register stay in wb_result_stage.

Test Plan:
- Reset: hold rst for 2 cycles with arbitrary inputs -> out_valid=0, result=0, rd_out=0, reg_write_out=0.
- ALU source: src0=0xDEADBEEF, result_src=0, rd_in=5, reg_write_in=1, in_valid=1 -> next cycle result=0xDEADBEEF, rd_out=5, reg_write_out=1.
- Signed byte load: src1=0x12F4_8000, result_src=1, load_size=00, byte_offset=2, load_unsigned=0 -> result=0xFFFFFFF4. Same stimulus with load_unsigned=1 -> result=0x000000F4.
- Half load: src1=0x8001_7FFF.
  - byte_offset=2, signed -> result=0xFFFF8001.
  - byte_offset=0 -> result=0x00007FFF.
  - byte_offset=1 -> result=0x00007FFF (bit 0 ignored).
- Stall and flush:
  - Capture 0x11 in the stage, then stall=1 for 3 cycles while inputs change -> outputs hold 0x11.
  - Assert flush and stall together -> next cycle out_valid=0, reg_write_out=0, result=0.
- Guards:
  - rd_in=0 with reg_write_in=1 -> reg_write_out=0.
  - NUM_SRC=3 build with result_src=3 -> result=0.
  - Random back-to-back traffic against a reference model with no stalls -> one result per cycle, latency 1.
